fanout_fork: RTL
================

Name: fanout_fork

Overview:
- Parametrised one-to-N stream fork for the sparse-accelerator datapath. Broadcasts a single upstream valid/ready stream to a configurable subset of downstream channels.
- Generalises the combinational all-destinations-ready fanout term: adds configurable channel count and data width, a destination mask, and a sequential eager mode. In eager mode a per-destination "delivered" register lets each destination accept independently.
- Sits between a primitive's output stream and its routed consumers.

Parameters:
- N_OUT, 7, number of downstream channels (1..32).
- DATA_WIDTH, 17, stream word width (16 data bits + 1 control bit).
- CNT_WIDTH, 32, width of performance counters (used only when FANOUT_PERF_CNT_EN is defined).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of tracking state and counters.
- cfg_dest_mask  in  N_OUT  bit i set = channel i is a destination (enable AND select, already combined); static during operation.
- cfg_eager  in  1  1 = eager mode (independent acceptance); 0 = lockstep mode.
- in_data  in  DATA_WIDTH  upstream word.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- out_data  out  N_OUT*DATA_WIDTH  per-channel word (all channels carry in_data).
- out_valid  out  N_OUT  per-channel valid.
- out_ready  in  N_OUT  per-channel ready.
- busy  out  1  OR of the delivered register (a token is partially delivered).

Behaviour:
- Data path is fully combinational, zero latency: out_data[i] = in_data for every i.
- State: delivered register D[N_OUT-1:0]. Reset value is 0. Reset is asynchronous: on rst_n low, D and all counters go to 0 immediately, regardless of clk.
- Reset values of outputs follow from D = 0: busy = 0; out_valid = in_valid & cfg_dest_mask; in_ready = all masked destinations ready. If cfg_dest_mask = 0, in_ready = 1 (upstream words are discarded).
- Pending set: P = cfg_dest_mask & ~D. Upstream transfer T = in_valid & in_ready.
- Lockstep mode (cfg_eager = 0):
  - all_rdy = AND over i of (~cfg_dest_mask[i] | out_ready[i]).
  - out_valid[i] = in_valid & cfg_dest_mask[i] & all_rdy; in_ready = all_rdy.
  - D stays 0. A combinational ready-to-valid path is permitted and documented for this mode.
- Eager mode (cfg_eager = 1):
  - out_valid[i] = in_valid & P[i], independent of any out_ready.
  - in_ready = AND over i of (~P[i] | out_ready[i]).
  - Next D: if T, D <= 0; else D <= D | (out_valid & out_ready).
  - Each destination therefore sees each token exactly once.
- Simultaneous final accepts: if every remaining pending channel is ready in the same cycle, T fires that cycle and D clears. No extra bubble.
- Upstream protocol: in_valid and in_data must stay stable until T. Dropping in_valid while busy is a protocol violation; D holds its value and no output is asserted.
- cfg_dest_mask and cfg_eager may change only when busy = 0. If the mask is changed while busy, D bits of unmasked channels are ignored, because only P is used.
- flush (synchronous, highest priority over D update): D <= 0 and counters <= 0. During the flush cycle, out_valid = 0 and in_ready = 0.
- Reset mid-token: the token is forgotten. Upstream re-presents it after reset.

Optional Feature:
- Macro: FANOUT_PERF_CNT_EN.
- When defined, two output ports are added:
  - stall_cnt (CNT_WIDTH): counts cycles with in_valid & ~in_ready & ~flush.
  - token_cnt (CNT_WIDTH): counts T.
  - Both saturate at all-ones, clear on flush, and reset to 0.
- When undefined, both ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fanout_pkg holds:
  - typedef fanout_mode_e (FANOUT_LOCKSTEP = 0, FANOUT_EAGER = 1);
  - localparam FANOUT_MAX_OUT = 32;
  - default CNT_WIDTH.
- One sub-module, fanout_ack_tracker: contains the D register, pending/in_ready logic and flush handling.
- The top level does broadcast wiring, mode muxing and the optional counters.

Test Plan:
- Lockstep, N_OUT = 7, mask = 7'b1000101, in_valid = 1, out_ready = 7'b0000101:
  - in_ready = 0 and out_valid = 0.
  - When out_ready[6] rises, out_valid = 7'b1000101 and in_ready = 1 in the same cycle.
- Eager, mask = 7'b0000111, out_ready pattern per cycle 001, 100, 010:
  - D goes 001 then 101.
  - T fires on the third cycle and D returns to 0.
  - Each channel sees exactly one valid&ready for token 0xA5.
- Mask = 0, in_valid held high for 5 cycles: in_ready = 1 every cycle, out_valid = 0, 5 transfers counted.
- Eager with D = 7'b0000011, flush asserted: that cycle out_valid = 0 and in_ready = 0; next cycle D = 0 and busy = 0.
- Eager with D = 7'b0000001, rst_n pulsed low mid-cycle: D = 0 before the next clk edge.
- FANOUT_PERF_CNT_EN defined, CNT_WIDTH = 4, 20 stall cycles: stall_cnt saturates at 15; 3 transfers give token_cnt = 3.

Source files
------------

// File: rtl/fanout_fork_pkg.sv
// Shared types and limits for the one-to-N stream fork.
// The mode enum names how cfg_eager is interpreted by the tracker and top.
package fanout_pkg;

  typedef enum logic {
    FANOUT_LOCKSTEP = 1'b0,
    FANOUT_EAGER    = 1'b1
  } fanout_mode_e;

  localparam int FANOUT_MAX_OUT   = 32;
  localparam int FANOUT_CNT_WIDTH = 32;

endpackage

// File: rtl/fanout_ack_tracker.sv
// Per-destination delivered register for eager fork mode; zero-latency handshake terms.
// Upstream ready drops while any pending destination is not ready; flush forces both directions idle.
module fanout_ack_tracker
  import fanout_pkg::*;
#(
  parameter int N_OUT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [N_OUT-1:0] cfg_dest_mask,
  input  logic             cfg_eager,
  input  logic             in_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [N_OUT-1:0] eager_valid,
  output logic             eager_ready,
  output logic             busy
);

  logic [N_OUT-1:0] d_q;
  logic [N_OUT-1:0] d_d;
  logic [N_OUT-1:0] pending;
  logic             xfer;
  fanout_mode_e     mode;

  assign mode    = fanout_mode_e'(cfg_eager);
  // Only pending bits matter, so stale D bits of unmasked channels are harmless.
  assign pending = cfg_dest_mask & ~d_q;

  assign eager_valid = flush ? '0 : ({N_OUT{in_valid}} & pending);
  assign eager_ready = ~flush & (&(~pending | out_ready));
  assign xfer        = in_valid & eager_ready;
  assign busy        = |d_q;

  always_comb begin
    d_d = d_q;
    if (flush) begin
      d_d = '0;
    end else if (mode != FANOUT_EAGER || xfer) begin
      d_d = '0;
    end else begin
      d_d = d_q | (eager_valid & out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/fanout_fork.sv
// One-to-N stream fork with destination mask, lockstep/eager modes, optional FANOUT_PERF_CNT_EN counters.
// Zero latency; lockstep holds upstream until all destinations are ready, eager lets each accept once per token.
module fanout_fork
  import fanout_pkg::*;
#(
  parameter int N_OUT      = 7,
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = FANOUT_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [N_OUT-1:0]            cfg_dest_mask,
  input  logic                        cfg_eager,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_OUT*DATA_WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
`ifdef FANOUT_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]        stall_cnt,
  output logic [CNT_WIDTH-1:0]        token_cnt,
`endif
  output logic                        busy
);

  if (N_OUT < 1 || N_OUT > FANOUT_MAX_OUT || CNT_WIDTH < 1) begin : g_cfg_err
    $error("fanout_fork: unsupported N_OUT or CNT_WIDTH");
  end

  logic [N_OUT-1:0] eager_valid;
  logic             eager_ready;
  logic             all_rdy;
  logic [N_OUT-1:0] lock_valid;
  logic             lock_ready;
  fanout_mode_e     mode;

  assign mode = fanout_mode_e'(cfg_eager);

  for (genvar i = 0; i < N_OUT; i++) begin : g_bcast
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  fanout_ack_tracker #(
    .N_OUT(N_OUT)
  ) u_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .cfg_dest_mask(cfg_dest_mask),
    .cfg_eager    (cfg_eager),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .eager_valid  (eager_valid),
    .eager_ready  (eager_ready),
    .busy         (busy)
  );

  // Lockstep mode has a combinational out_ready -> out_valid/in_ready path by design.
  assign all_rdy    = &(~cfg_dest_mask | out_ready);
  assign lock_valid = flush ? '0 : ({N_OUT{in_valid & all_rdy}} & cfg_dest_mask);
  assign lock_ready = ~flush & all_rdy;

  always_comb begin
    out_valid = lock_valid;
    in_ready  = lock_ready;
    if (mode == FANOUT_EAGER) begin
      out_valid = eager_valid;
      in_ready  = eager_ready;
    end
  end

`ifdef FANOUT_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] token_q, token_d;

  always_comb begin
    stall_d = stall_q;
    token_d = token_q;
    if (flush) begin
      stall_d = '0;
      token_d = '0;
    end else begin
      if (in_valid && !in_ready && stall_q != '1) stall_d = stall_q + 1'b1;
      if (in_valid && in_ready && token_q != '1) token_d = token_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      token_q <= '0;
    end else begin
      stall_q <= stall_d;
      token_q <= token_d;
    end
  end

  assign stall_cnt = stall_q;
  assign token_cnt = token_q;
`endif

endmodule
